// File: rtl/seg7_scan_sched_if.sv
// Write port of the 7-segment scan scheduler.
// A producer (master) pushes one segment pattern per accepted handshake into the
// shadow bank. The scheduler (slave) holds wr_ready low on the frame-commit cycle.
//   wr_valid : producer has a pattern to write
//   wr_ready : scheduler accepts on wr_valid && wr_ready
//   wr_addr  : digit index, 0 = rightmost (AN[0])
//   wr_data  : active-high pattern {CA,CB,CC,CD,CE,CF,CG,DP}
interface seg7_scan_sched_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/seg7_scan_sched.sv
// Time-multiplexing scheduler for an 8-digit common-anode 7-segment display.
// Patterns are written into a shadow bank and copied to the active bank only at
// frame boundaries, so one frame never mixes old and new patterns. Each digit slot
// starts with an all-anodes-off blank interval, followed by a PWM-dimmed drive interval.
//   CLK100MHZ  : board clock
//   rstn       : synchronous active-low reset
//   en         : scan enable, low keeps the display dark and idle
//   bright     : drive duty, 0 = 1/16 .. 15 = 16/16
//   wr         : shadow-bank write port (slave side)
//   seg_n      : registered active-low segments {CA..CG,DP}
//   an_n       : registered active-low anode enables
//   cur_digit  : registered index of the digit being scanned
//   frame_done : one-cycle pulse after each frame commit
module seg7_scan_sched #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic             CLK100MHZ,
    input  logic             rstn,
    input  logic             en,
    input  logic [3:0]       bright,
    seg7_scan_sched_if.slave wr,
    output logic [7:0]       seg_n,
    output logic [7:0]       an_n,
    output logic [2:0]       cur_digit,
    output logic             frame_done
);

    // At least 4 bits so the PWM compare can always use cnt[3:0].
    localparam int unsigned CntW = ($clog2(TICK_DIV) < 4) ? 4 : $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntLast   = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      dig_q, dig_d;
    logic [7:0]      shadow_q [8];
    logic [7:0]      shadow_d [8];
    logic [7:0]      active_q [8];
    logic [7:0]      active_d [8];
    logic            dirty_q, dirty_d;
    logic            rstn_q;
    logic [7:0]      seg_n_q, seg_n_d;
    logic [7:0]      an_n_q, an_n_d;
    logic [2:0]      cur_digit_q, cur_digit_d;
    logic            frame_done_q, frame_done_d;
    logic            swap_cycle;
    logic            wr_fire;

    // Last cycle of digit 7: the frame commit point.
    assign swap_cycle = (state_q == StDrive) && (dig_q == 3'd7) && (cnt_q == CntLast);

    // Blocking writes on the commit cycle keeps the shadow->active copy race-free.
    assign wr.wr_ready = rstn_q & ~swap_cycle;
    assign wr_fire     = wr.wr_valid & wr.wr_ready;

    // Scan FSM and slot/digit counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                dig_d = '0;
                if (en) state_d = StBlank;
            end
            StBlank: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BlankLast) state_d = StDrive;
            end
            StDrive: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    dig_d   = dig_q + 3'd1;
                    state_d = StBlank;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            dig_d   = '0;
        end
    end

    // Pattern banks. A write always marks dirty, even in idle, so a write landing on
    // the last idle cycle is still committed at the end of the first frame.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (state_q == StIdle) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
        end else if (swap_cycle && dirty_q) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
        end
        if (wr_fire) begin
            shadow_d[wr.wr_addr] = wr.wr_data;
            dirty_d              = 1'b1;
        end
    end

    // Pin drive. Segments are already valid during blank so they settle before the anode.
    always_comb begin
        seg_n_d      = 8'hFF;
        an_n_d       = 8'hFF;
        cur_digit_d  = dig_q;
        frame_done_d = swap_cycle & en;
        if (state_q != StIdle) seg_n_d = ~active_q[dig_q];
        if ((state_q == StDrive) && (cnt_q[3:0] <= bright)) an_n_d = ~(8'd1 << dig_q);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dig_q        <= '0;
            shadow_q     <= '{default: 8'h00};
            active_q     <= '{default: 8'h00};
            dirty_q      <= 1'b0;
            rstn_q       <= 1'b0;
            seg_n_q      <= 8'hFF;
            an_n_q       <= 8'hFF;
            cur_digit_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            dirty_q      <= dirty_d;
            rstn_q       <= 1'b1;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            cur_digit_q  <= cur_digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign cur_digit  = cur_digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_sched.sv
module tb_seg7_scan_sched;
    localparam int TD     = 8;
    localparam int BC     = 2;
    localparam int FRAME  = 8 * TD;
    localparam int TD2    = 64;
    localparam int BC2    = 16;
    localparam int FRAME2 = 8 * TD2;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] bright;
    logic [7:0] seg_n, an_n, seg_n2, an_n2;
    logic [2:0] cur_digit, cur_digit2;
    logic       frame_done, frame_done2;

    seg7_scan_sched_if wr1 ();
    seg7_scan_sched_if wr2 ();

    seg7_scan_sched #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .CLK100MHZ  (clk),
        .rstn       (rstn),
        .en         (en),
        .bright     (bright),
        .wr         (wr1),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    seg7_scan_sched #(.TICK_DIV(TD2), .BLANK_CYC(BC2)) dut_dim (
        .CLK100MHZ  (clk),
        .rstn       (rstn),
        .en         (en),
        .bright     (bright),
        .wr         (wr2),
        .seg_n      (seg_n2),
        .an_n       (an_n2),
        .cur_digit  (cur_digit2),
        .frame_done (frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time since enable, plus the two banks as plain arrays.
    logic       scan;
    int         pos;
    logic       rq;
    logic [7:0] shadow_m [8];
    logic [7:0] active_m [8];
    logic       last_fire;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pos=%0d got %h expected %h", tag, pos, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_an(input int p, input int td, input int bc,
                                          input logic [3:0] br);
        int c;
        int d;
        c = p % td;
        d = (p / td) % 8;
        if (c >= bc && (c % 16) <= int'(br)) return ~(8'd1 << d);
        return 8'hFF;
    endfunction

    task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d);
        logic       swap, exp_rdy, e_fd, e_fd2;
        logic [7:0] e_an, e_seg, e_an2;
        logic [2:0] e_cd, e_cd2;
        wr1.wr_valid = v;
        wr1.wr_addr  = a;
        wr1.wr_data  = d;
        swap    = scan && (pos % FRAME == FRAME - 1);
        exp_rdy = rq && !swap;
        chk("wr_ready", {7'd0, wr1.wr_ready}, {7'd0, exp_rdy});
        last_fire = v && exp_rdy && rstn;
        if (scan && rstn) begin
            e_an  = exp_an(pos, TD, BC, bright);
            e_seg = ~active_m[(pos / TD) % 8];
            e_cd  = 3'((pos / TD) % 8);
            e_fd  = swap && en;
            e_an2 = exp_an(pos, TD2, BC2, bright);
            e_cd2 = 3'((pos / TD2) % 8);
            e_fd2 = (pos % FRAME2 == FRAME2 - 1) && en;
        end else begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
            e_cd  = 3'd0;
            e_fd  = 1'b0;
            e_an2 = 8'hFF;
            e_cd2 = 3'd0;
            e_fd2 = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("an_n", an_n, e_an);
        chk("seg_n", seg_n, e_seg);
        chk("cur_digit", {5'd0, cur_digit}, {5'd0, e_cd});
        chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
        chk("dim_an_n", an_n2, e_an2);
        chk("dim_seg_n", seg_n2, 8'hFF);
        chk("dim_cur_digit", {5'd0, cur_digit2}, {5'd0, e_cd2});
        chk("dim_frame_done", {7'd0, frame_done2}, {7'd0, e_fd2});
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                shadow_m[i] = 8'h00;
                active_m[i] = 8'h00;
            end
            scan = 1'b0;
            pos  = 0;
            rq   = 1'b0;
        end else begin
            // Idle keeps active tracking shadow; otherwise shadow is copied at frame end.
            if (!scan || swap) active_m = shadow_m;
            if (last_fire) shadow_m[a] = d;
            rq = 1'b1;
            if (en) begin
                pos  = scan ? pos + 1 : 0;
                scan = 1'b1;
            end else begin
                scan = 1'b0;
                pos  = 0;
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 8'h00);
    endtask

    // Producer behaviour: hold the request until it is accepted.
    task automatic write_hold(input logic [2:0] a, input logic [7:0] d);
        int tries;
        tries     = 0;
        last_fire = 1'b0;
        while (!last_fire && tries < 8) begin
            step(1'b1, a, d);
            tries++;
        end
        wr1.wr_valid = 1'b0;
    endtask

    initial begin
        rstn         = 1'b0;
        en           = 1'b1;
        bright       = 4'd15;
        wr1.wr_valid = 1'b0;
        wr1.wr_addr  = 3'd0;
        wr1.wr_data  = 8'h00;
        wr2.wr_valid = 1'b0;
        wr2.wr_addr  = 3'd0;
        wr2.wr_data  = 8'h00;
        scan = 1'b0;
        pos  = 0;
        rq   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            shadow_m[i] = 8'h00;
            active_m[i] = 8'h00;
        end
        @(posedge clk);
        #1;

        // Reset held with en high, then release straight into scanning.
        idle_steps(3);
        rstn = 1'b1;
        idle_steps(20);

        // Mid-frame write only shows after the next commit.
        write_hold(3'd3, 8'hFC);
        idle_steps(3 * FRAME);

        // Load every digit, then watch the full scan order.
        for (int i = 0; i < 8; i++) write_hold(3'(i), 8'($urandom));
        idle_steps(2 * FRAME + 4);

        // Write request held across the commit cycle.
        for (int k = 0; k < FRAME + 2 && !(scan && pos % FRAME == FRAME - 2); k++)
            step(1'b0, 3'd0, 8'h00);
        step(1'b0, 3'd0, 8'h00);
        write_hold(3'd5, 8'hA5);
        idle_steps(2 * FRAME);

        // Random writes and brightness.
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) write_hold(3'($urandom), 8'($urandom));
            else step(1'b0, 3'd0, 8'h00);
        end

        // Dimming over a full frame of the long-slot instance.
        bright = 4'd3;
        idle_steps(FRAME2 + 8);
        bright = 4'd15;

        // Disable mid-drive, write while idle, re-enable.
        for (int k = 0; k < TD + 2 && !(scan && pos % TD == 4); k++) step(1'b0, 3'd0, 8'h00);
        en = 1'b0;
        idle_steps(3);
        write_hold(3'd6, 8'h3C);
        idle_steps(2);
        en = 1'b1;
        idle_steps(FRAME + 10);

        // Reset during blank.
        for (int k = 0; k < TD + 2 && !(scan && pos % TD == 0 && pos > 0); k++)
            step(1'b0, 3'd0, 8'h00);
        rstn = 1'b0;
        idle_steps(2);
        rstn = 1'b1;
        idle_steps(FRAME + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_sched.md
# seg7_scan_sched

Time-multiplexing scheduler for the Nexys 8-digit common-anode 7-segment display. It holds a double-buffered 8-entry segment-pattern store and drives `CA..DP`/`AN` one digit at a time. Each digit slot is split into an anti-ghosting blank interval and a PWM-dimmed drive interval. It sits between pattern producers and the display pins. Pattern updates are committed only at frame boundaries, so a frame never mixes old and new patterns.

## Interface
- `TICK_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 4.
- `BLANK_CYC`, 1000: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < TICK_DIV.
- `CLK100MHZ`  in  1  board clock; every register updates on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `en`  in  1  scan enable; low forces IDLE with the display dark.
- `wr_valid`  in  1  write request to the shadow bank.
- `wr_ready`  out  1  write accepted on cycles where `wr_valid && wr_ready`.
- `wr_addr`  in  3  digit index (0 = rightmost, AN[0]).
- `wr_data`  in  8  segment pattern, active-high, bit7..bit0 = CA,CB,CC,CD,CE,CF,CG,DP.
- `bright`  in  4  drive duty: 0 = 1/16 on, 15 = 16/16 on.
- `seg_n`  out  8  {CA,CB,CC,CD,CE,CF,CG,DP}, active-low, registered.
- `an_n`  out  8  anode enables, active-low, registered.
- `cur_digit`  out  3  digit index currently being scanned, registered.
- `frame_done`  out  1  one-cycle pulse after each committed frame boundary.

## Operation
- Storage:
  - `shadow[0:7]` receives all writes.
  - `active[0:7]` feeds the pins.
  - `dirty` flag: set by any accepted write; cleared on commit.
- Slot counter `cnt` counts 0..TICK_DIV-1. Digit index `dig` counts 0..7 and wraps from 7 to 0.
- FSM states IDLE, BLANK, DRIVE:
  - IDLE:
    - `cnt`=0, `dig`=0, `an_n`=FF, `seg_n`=FF.
    - `active` copies `shadow` every cycle, so a write lands in `active` 2 cycles after acceptance.
    - `dirty` is cleared.
    - Exit to BLANK when `en`=1.
  - BLANK:
    - Active while `cnt` < BLANK_CYC.
    - `an_n`=FF. `seg_n` is already driven with `~active[dig]` so segments settle before the anode turns on.
    - Go to DRIVE when `cnt`=BLANK_CYC-1.
  - DRIVE:
    - Active while BLANK_CYC <= `cnt` <= TICK_DIV-1.
    - `seg_n`=~active[dig].
    - `an_n`=~(1<<dig) when `cnt[3:0]` <= `bright`, else FF.
    - At `cnt`=TICK_DIV-1: `cnt`->0, `dig`->dig+1, state->BLANK.
  - Any state: `en`=0 forces IDLE on the next cycle.
- Commit (swap) cycle = DRIVE with `dig`=7 and `cnt`=TICK_DIV-1:
  - If `dirty`: `active`<=`shadow`, `dirty`<=0.
  - `wr_ready`=0 on this cycle only, so no write can race the copy.
- `wr_ready` = rstn_q & ~swap_cycle. It is combinational from registered state and is 1 in IDLE.
- Writes to the same address overwrite: last accepted write wins.

## Timing
- Reset (`rstn`=0 sampled on an edge): on the following edge:
  - state=IDLE, `cnt`=0, `dig`=0.
  - `shadow`/`active`=all 00, `dirty`=0.
  - `seg_n`=FF, `an_n`=FF, `cur_digit`=0, `frame_done`=0.
- `wr_ready`=0 while `rstn`=0 and for the first cycle after release. It is 1 from the second cycle onward.
- Reset mid-scan aborts the slot immediately. Shadow contents are lost.
- Pin outputs are registered: `an_n`/`seg_n`/`cur_digit` reflect the state/`cnt`/`dig` of the previous cycle.
- `frame_done` is high the cycle after every swap cycle, whether or not `dirty` was set. It never asserts in IDLE.
- `en` 0->1: the first BLANK cycle is the cycle after `en` is sampled high. `an_n` of digit 0 first goes low BLANK_CYC+1 cycles later (subject to PWM).
- `en` 1->0: `an_n`=FF from the second edge after `en` is sampled low.
- `bright` is sampled every cycle; a change affects the next PWM compare.
- Simultaneous `wr_valid` and swap cycle: the write is not accepted; the producer must hold it.
- Simultaneous write and commit is impossible by construction. A write accepted on the cycle before a swap is included in that swap.

## Test plan
- Use TICK_DIV=8, BLANK_CYC=2, bright=15 throughout unless stated.
- Reset: hold `rstn`=0 three cycles with `en`=1 -> `an_n`=FF, `seg_n`=FF, `frame_done`=0. After release, `wr_ready`=0 for one cycle, then 1.
- Write `shadow[3]`=8'hFC while `en`=1 mid-frame -> digit 3 shows `seg_n`=03 only in the frame after the next `frame_done` pulse. The current frame still shows 00.
- Scan order: all digits loaded, `en`=1 -> `an_n` sequence FE,FD,FB,...,7F. Each anode is low for 6 cycles preceded by 2 FF cycles. `frame_done` pulses every 64 cycles.
- Swap collision: `wr_valid` held high across the swap cycle -> `wr_ready`=0 for exactly that cycle. The write is accepted the next cycle and appears one frame later.
- Dimming: bright=3 with TICK_DIV=64, BLANK_CYC=16 -> within DRIVE, `an_n` is low only where `cnt[3:0]`<=3, i.e. 4 of every 16 cycles.
- Disable: drop `en` mid-DRIVE -> `an_n`=FF within 2 cycles. A write in IDLE appears in `active` (observed via re-enable) with no frame wait. `rstn`=0 mid-BLANK -> all outputs return to reset values.
